// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch
// Brief   : Single-outstanding instruction fetch stage with IF/ID register,
//           decode-stall skid (hold) register and flush/discard handling.
// Revision: 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ce,
    output logic              pc_stall,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    input  logic              flush,
    input  logic              id_stall,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [INST_W-1:0] if_id_inst
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_discard;
    logic              w_discard_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_tag;
    logic [INST_W-1:0] r_hold;
    logic              r_if_id_valid;
    logic [ADDR_W-1:0] r_if_id_pc;
    logic [INST_W-1:0] r_if_id_inst;
    logic              w_launch;
    logic              w_hold_load;
    logic              w_out_load;
    logic [INST_W-1:0] w_out_data;

    assign pc_stall      = (r_state != S_IDLE);
    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_addr  = r_addr;
    assign if_id_valid   = r_if_id_valid;
    assign if_id_pc      = r_if_id_pc;
    assign if_id_inst    = r_if_id_inst;

    always_comb begin
        w_state_nxt   = r_state;
        w_discard_nxt = r_discard;
        w_launch      = 1'b0;
        w_hold_load   = 1'b0;
        w_out_load    = 1'b0;
        w_out_data    = mem_rsp_data;
        case (r_state)
            S_IDLE: begin
                if (ce && !flush) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // The request stays up until accepted; a flush only marks it dead.
                if (flush)         w_discard_nxt = 1'b1;
                if (mem_req_ready) w_state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    if (r_discard || flush) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_IDLE;
                    end else if (!r_if_id_valid || !id_stall) begin
                        w_out_load  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_hold_load = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (flush) begin
                    w_discard_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (!id_stall) begin
                    w_out_load  = 1'b1;
                    w_out_data  = r_hold;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_discard <= 1'b0;
            r_addr    <= '0;
            r_tag     <= '0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
            if (w_launch) begin
                r_addr <= pc;
                r_tag  <= pc;
            end
            if (w_hold_load) r_hold <= mem_rsp_data;
        end
    end

    // Flush wins over a load; an unstalled decode consumes the current word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_inst  <= NOP_INST;
        end else if (flush) begin
            r_if_id_valid <= 1'b0;
            r_if_id_inst  <= NOP_INST;
        end else if (w_out_load) begin
            r_if_id_valid <= 1'b1;
            r_if_id_pc    <= r_tag;
            r_if_id_inst  <= w_out_data;
        end else if (!id_stall) begin
            r_if_id_valid <= 1'b0;
            r_if_id_inst  <= NOP_INST;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_fetch
// Brief   : Directed + randomized bench for inst_fetch against a
//           transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam int          AW  = 32;
    localparam int          IW  = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic          ce;
    logic          pc_stall;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [IW-1:0] mem_rsp_data;
    logic          flush;
    logic          id_stall;
    logic          if_id_valid;
    logic [AW-1:0] if_id_pc;
    logic [IW-1:0] if_id_inst;

    inst_fetch #(.ADDR_W(AW), .INST_W(IW), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .ce           (ce),
        .pc_stall     (pc_stall),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .flush        (flush),
        .id_stall     (id_stall),
        .if_id_valid  (if_id_valid),
        .if_id_pc     (if_id_pc),
        .if_id_inst   (if_id_inst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one optional in-flight transaction plus the decode slot.
    logic          m_have;   // a fetch is in progress
    logic          m_acc;    // its request has been accepted by memory
    logic          m_kill;   // its response must be thrown away
    logic          m_held;   // its word is parked waiting for decode
    logic [AW-1:0] m_addr;
    logic [IW-1:0] m_word;
    logic          m_valid;
    logic [AW-1:0] m_pc;
    logic [IW-1:0] m_inst;

    task automatic model_reset();
        m_have = 0; m_acc = 0; m_kill = 0; m_held = 0;
        m_addr = '0; m_word = '0;
        m_valid = 0; m_pc = '0; m_inst = NOP;
    endtask

    task automatic model_edge();
        logic          load;
        logic [IW-1:0] ld;
        load = 0;
        ld   = '0;
        if (!m_have) begin
            if (ce && !flush) begin
                m_have = 1; m_acc = 0; m_kill = 0; m_held = 0; m_addr = pc;
            end
        end else if (!m_acc) begin
            if (flush)         m_kill = 1;
            if (mem_req_ready) m_acc  = 1;
        end else if (!m_held) begin
            if (mem_rsp_valid) begin
                if (m_kill || flush) begin
                    m_have = 0; m_kill = 0;
                end else if (!m_valid || !id_stall) begin
                    load = 1; ld = mem_rsp_data; m_have = 0;
                end else begin
                    m_held = 1; m_word = mem_rsp_data;
                end
            end else if (flush) begin
                m_kill = 1;
            end
        end else begin
            if (flush) m_have = 0;
            else if (!id_stall) begin
                load = 1; ld = m_word; m_have = 0;
            end
        end
        if (flush) begin
            m_valid = 0; m_inst = NOP;
        end else if (load) begin
            m_valid = 1; m_pc = m_addr; m_inst = ld;
        end else if (!id_stall) begin
            m_valid = 0; m_inst = NOP;
        end
    endtask

    task automatic check_outputs();
        check_eq("pc_stall",      64'(pc_stall),      64'(m_have));
        check_eq("mem_req_valid", 64'(mem_req_valid), 64'(m_have && !m_acc));
        check_eq("mem_req_addr",  64'(mem_req_addr),  64'(m_addr));
        check_eq("if_id_valid",   64'(if_id_valid),   64'(m_valid));
        check_eq("if_id_pc",      64'(if_id_pc),      64'(m_pc));
        check_eq("if_id_inst",    64'(if_id_inst),    64'(m_inst));
    endtask

    // Drive one cycle of inputs, advance the model and the DUT, then compare.
    task automatic step(input logic c, input logic [AW-1:0] p, input logic rdy,
                        input logic rv, input logic [IW-1:0] rd,
                        input logic fl, input logic st);
        ce = c; pc = p; mem_req_ready = rdy; mem_rsp_valid = rv;
        mem_rsp_data = rd; flush = fl; id_stall = st;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic st);
        step(0, '0, 0, 0, '0, 0, st);
    endtask

    initial begin
        rst = 0; ce = 0; pc = '0; mem_req_ready = 0; mem_rsp_valid = 0;
        mem_rsp_data = '0; flush = 0; id_stall = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check_eq("reset_inst_nop", 64'(if_id_inst), 64'(NOP));
        rst = 1;

        // Basic fetch
        step(1, 32'h100, 0, 0, '0, 0, 0);
        check_eq("basic_req_valid", 64'(mem_req_valid), 64'd1);
        check_eq("basic_req_addr",  64'(mem_req_addr),  64'h100);
        step(0, '0, 1, 0, '0, 0, 0);
        step(0, '0, 0, 1, 32'h00500093, 0, 0);
        check_eq("basic_valid",    64'(if_id_valid), 64'd1);
        check_eq("basic_pc",       64'(if_id_pc),    64'h100);
        check_eq("basic_inst",     64'(if_id_inst),  64'h00500093);
        check_eq("basic_pc_stall", 64'(pc_stall),    64'd0);

        // Backpressure: three cycles not ready, then accept
        step(1, 32'h200, 0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, 0, '0, 0, 0);
            check_eq("bp_req_valid", 64'(mem_req_valid), 64'd1);
            check_eq("bp_req_addr",  64'(mem_req_addr),  64'h200);
        end
        step(0, '0, 1, 0, '0, 0, 0);
        check_eq("bp_one_accept", 64'(mem_req_valid), 64'd0);
        step(0, '0, 0, 1, 32'h11111111, 0, 0);

        // Decode stall parks the word in HOLD
        step(1, 32'h300, 0, 0, '0, 0, 1);
        step(0, '0, 1, 0, '0, 0, 1);
        step(0, '0, 0, 1, 32'hDEADBEEF, 0, 1);
        check_eq("hold_stall",     64'(pc_stall),   64'd1);
        check_eq("hold_inst_kept", 64'(if_id_inst), 64'h11111111);
        idle(1);
        idle(0);
        check_eq("hold_release_inst", 64'(if_id_inst), 64'hDEADBEEF);
        check_eq("hold_release_pc",   64'(if_id_pc),   64'h300);

        // Flush while waiting for the response
        step(1, 32'h400, 0, 0, '0, 0, 1);
        step(0, '0, 1, 0, '0, 0, 1);
        step(0, '0, 0, 0, '0, 1, 1);
        step(0, '0, 0, 1, 32'h12345678, 0, 0);
        check_eq("fw_valid", 64'(if_id_valid), 64'd0);
        check_eq("fw_inst",  64'(if_id_inst),  64'h13);
        check_eq("fw_idle",  64'(pc_stall),    64'd0);

        // Flush coincident with the response
        step(1, 32'h500, 0, 0, '0, 0, 0);
        step(0, '0, 1, 0, '0, 0, 0);
        step(0, '0, 0, 1, 32'h55555555, 1, 0);
        check_eq("fc_valid", 64'(if_id_valid), 64'd0);

        // Flush in HOLD, then a clean fetch
        step(1, 32'h600, 0, 0, '0, 0, 0);
        step(0, '0, 1, 0, '0, 0, 0);
        step(0, '0, 0, 1, 32'hAAAA0001, 0, 0);
        step(1, 32'h700, 0, 0, '0, 0, 1);
        step(0, '0, 1, 0, '0, 0, 1);
        step(0, '0, 0, 1, 32'hBBBB0002, 0, 1);
        step(0, '0, 0, 0, '0, 1, 1);
        check_eq("fh_valid", 64'(if_id_valid), 64'd0);
        check_eq("fh_idle",  64'(pc_stall),    64'd0);
        step(1, 32'h800, 0, 0, '0, 1, 0);
        check_eq("fi_no_launch", 64'(pc_stall), 64'd0);
        step(1, 32'h800, 0, 0, '0, 0, 0);
        step(0, '0, 1, 0, '0, 0, 0);
        step(0, '0, 0, 1, 32'hCCCC0003, 0, 0);
        check_eq("refetch_pc",   64'(if_id_pc),   64'h800);
        check_eq("refetch_inst", 64'(if_id_inst), 64'hCCCC0003);

        // Asynchronous reset in the middle of a request
        step(1, 32'h900, 0, 0, '0, 0, 0);
        #2;
        rst = 0;
        model_reset();
        #1;
        check_eq("areset_req_valid", 64'(mem_req_valid), 64'd0);
        check_outputs();
        ce = 0; mem_req_ready = 0; mem_rsp_valid = 0; flush = 0; id_stall = 0;
        #1;
        rst = 1;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
        step(0, '0, 0, 1, 32'hFEEDFACE, 0, 0);
        check_eq("stray_rsp", 64'(if_id_valid), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 3, $urandom,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the instruction address width.
REQ-002 Parameter INST_W, default 32, SHALL set the instruction word width.
REQ-003 Parameter NOP_INST, default 32'h00000013, SHALL be the bubble instruction driven when no valid instruction is presented.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 pc  input  ADDR_W  SHALL carry the fetch address from the PC register.
REQ-007 ce  input  1  SHALL indicate pc is valid, i.e. fetch is enabled.
REQ-008 pc_stall  output  1  SHALL tell the PC register to hold pc.
REQ-009 mem_req_valid  output  1  SHALL carry the instruction-memory request valid.
REQ-010 mem_req_addr  output  ADDR_W  SHALL carry the request address.
REQ-011 mem_req_ready  input  1  SHALL indicate memory accepts the request.
REQ-012 mem_rsp_valid  input  1  SHALL indicate that the response word is present.
REQ-013 mem_rsp_data  input  INST_W  SHALL carry the fetched instruction.
REQ-014 flush  input  1  SHALL signal a redirect/kill of all in-flight fetch work.
REQ-015 id_stall  input  1  SHALL signal that decode cannot accept a new instruction.
REQ-016 if_id_valid  output  1  SHALL indicate that the IF/ID register holds a valid instruction.
REQ-017 if_id_pc  output  ADDR_W  SHALL carry the address of the presented instruction.
REQ-018 if_id_inst  output  INST_W  SHALL carry the presented instruction, or NOP_INST when invalid.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT and HOLD; all outputs SHALL be registered except pc_stall and mem_req_valid, which SHALL decode the FSM state.
REQ-020 In IDLE with ce=1 and flush=0, the block SHALL latch pc into the address register and the pc value into the tag register, and SHALL go to REQ; otherwise it SHALL stay in IDLE.
REQ-021 pc_stall SHALL be 1 in every state except IDLE, and SHALL be 0 in IDLE.
REQ-022 In REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL equal the latched address, held stable until mem_req_ready=1.
REQ-023 The handshake in REQ SHALL complete in the cycle with mem_req_ready=1, and the FSM SHALL then go to WAIT; a request SHALL never be withdrawn before ready, including under flush.
REQ-024 In states other than REQ, mem_req_valid SHALL be 0.
REQ-025 In WAIT, mem_rsp_valid SHALL be monitored; a response arriving in any other state SHALL be ignored.
REQ-026 In WAIT, on a response with the discard flag clear and the output slot free (if_id_valid=0 or id_stall=0), if_id_* SHALL be loaded with {1, tag, mem_rsp_data} at the next edge and the FSM SHALL go to IDLE.
REQ-027 In WAIT, on a response with the slot busy (if_id_valid=1 and id_stall=1), the word SHALL be stored in the hold register and the FSM SHALL go to HOLD.
REQ-028 In HOLD, when id_stall=0 the hold register SHALL move to if_id_* and the FSM SHALL go to IDLE.
REQ-029 With id_stall=0 and no new load, if_id_valid SHALL clear to 0 and if_id_inst SHALL become NOP_INST.
REQ-030 With id_stall=1 and no flush, if_id_* SHALL hold their values.
REQ-031 Flush SHALL force if_id_valid=0 and if_id_inst=NOP_INST at the next edge, overriding any load that cycle.
REQ-032 Flush in REQ or WAIT SHALL set the discard flag; that transaction's response SHALL be dropped on arrival, the flag SHALL clear, and the FSM SHALL go to IDLE.
REQ-033 Flush in HOLD SHALL drop the held word and go to IDLE.
REQ-034 Flush in IDLE SHALL suppress the launch of a new fetch that cycle.
REQ-035 A flush coincident with a response in WAIT SHALL drop that response.
REQ-036 Latency SHALL be: ce sampled in IDLE at edge N gives mem_req_valid=1 in cycle N+1; a response in cycle K gives if_id_valid=1 after edge K (1-cycle response-to-decode).
REQ-037 At most one fetch SHALL be outstanding.
REQ-038 Address arithmetic SHALL NOT be performed; the pc value SHALL pass through unchanged at ADDR_W bits.

Reset
REQ-039 rst=0 SHALL immediately force: state IDLE, discard flag 0, mem_req_valid 0, mem_req_addr 0, if_id_valid 0, if_id_pc 0, if_id_inst NOP_INST, hold register cleared.
REQ-040 Reset asserted mid-transaction SHALL abandon the transaction; a response arriving after release SHALL be ignored (the FSM is in IDLE).

Verification
REQ-041 Basic fetch: ce=1, pc=0x100, ready=1, response 0x00500093 two cycles later -> if_id_valid=1, if_id_pc=0x100, if_id_inst=0x00500093; pc_stall=0 only in IDLE cycles.
REQ-042 Backpressure: ready held 0 for 3 cycles -> mem_req_valid=1 and mem_req_addr stable for all 4 cycles; exactly one request accepted.
REQ-043 Decode stall: if_id_valid=1, id_stall=1, response 0xDEADBEEF -> FSM enters HOLD, if_id_* unchanged; id_stall drops -> if_id_inst=0xDEADBEEF next edge.
REQ-044 Flush in WAIT: flush pulse, then response 0x12345678 -> if_id_valid stays 0, if_id_inst=0x00000013, FSM returns to IDLE.
REQ-045 Async reset: rst=0 asserted mid-cycle during REQ -> mem_req_valid=0 before the next edge; after release, a stray mem_rsp_valid produces no output.
REQ-046 Flush coincident with response, and flush in HOLD -> no valid output; the next ce fetches the new pc correctly.
